// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the digit entry / scan block.
`timescale 1ns/1ps
package digit_entry_pkg;

  typedef enum logic {
    SINGLE = 1'b0,
    SCAN   = 1'b1
  } mode_e;

  localparam int unsigned NUM_KEYS       = 6;
  localparam int unsigned KEY_COMMIT     = 4;
  localparam int unsigned KEY_MODE       = 5;
  localparam int unsigned KEY_NIB_MSB    = 0;
  localparam int unsigned NIB_W          = 4;
  localparam int unsigned DEF_NUM_DIGITS = 8;

  // Key KEY_NIB_MSB drives the nibble MSB; keys are active-low.
  function automatic logic [NIB_W-1:0] keys_to_nibble(input logic [NIB_W-1:0] ks_nib);
    logic [NIB_W-1:0] nib;
    nib = '0;
    for (int i = 0; i < int'(NIB_W); i++) begin
      nib[NIB_W-1-i] = ~ks_nib[i];
    end
    return nib;
  endfunction

endpackage

// File: rtl/digit_entry_scan_if.sv
// Key inputs and decoder-facing display signals of digit_entry_scan.
`timescale 1ns/1ps
interface digit_entry_scan_if #(
  parameter int unsigned NUM_DIGITS = digit_entry_pkg::DEF_NUM_DIGITS
);
  import digit_entry_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_DIGITS);

  logic [NUM_KEYS-1:0] key_n;
  logic [PTR_W-1:0]    cs_pointer;
  logic [NIB_W-1:0]    dig_val;
  logic                dig_dot;
  logic                dig_blank;
  logic [PTR_W:0]      fill_cnt;
  logic                scan_mode;

  // Key source / display sink side.
  modport master (
    output key_n,
    input  cs_pointer, dig_val, dig_dot, dig_blank, fill_cnt, scan_mode
  );

  // Digit entry block side.
  modport slave (
    input  key_n,
    output cs_pointer, dig_val, dig_dot, dig_blank, fill_cnt, scan_mode
  );

endinterface

// File: rtl/digit_entry_scan_key_sync_edge.sv
// N-stage synchroniser plus falling-edge (press) detector for active-low keys.
`timescale 1ns/1ps
module key_sync_edge #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_1kHz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_n,
  output logic [WIDTH-1:0] ks,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] ks_prev_q;
  logic [WIDTH-1:0] ks_prev_d;

  // Stages reset to released so a key held at reset needs a fresh 1->0 edge.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '1;
      end
      ks_prev_q <= '1;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      ks_prev_q <= ks_prev_d;
    end
  end

  always_comb begin
    sync_d[0] = d_n;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    ks_prev_d = sync_q[STAGES-1];
  end

  assign ks    = sync_q[STAGES-1];
  assign press = ks_prev_q & ~ks;

endmodule

// File: rtl/digit_entry_scan.sv
// Live hex nibble entry, 8-deep commit history and single/scan display selection.
`timescale 1ns/1ps
module digit_entry_scan
  import digit_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_1kHz,
  input  logic               rst_n,
  digit_entry_scan_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] press;
  logic [NIB_W-1:0]    live_nib;
  logic                do_commit;
  logic                do_toggle;
  logic                do_clear;
  logic                unused_key_bits_c;

  mode_e            mode_q, mode_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [NIB_W-1:0] digit_buf_q [NUM_DIGITS];
  logic [NIB_W-1:0] digit_buf_d [NUM_DIGITS];

  logic [NIB_W-1:0] dig_val_c;
  logic             dig_dot_c;
  logic             dig_blank_c;

  key_sync_edge #(
    .WIDTH  (NUM_KEYS),
    .STAGES (SYNC_STAGES)
  ) u_key_sync_edge (
    .clk_1kHz (clk_1kHz),
    .rst_n    (rst_n),
    .d_n      (bus.key_n),
    .ks       (ks),
    .press    (press)
  );

  assign live_nib  = keys_to_nibble(ks[KEY_NIB_MSB +: NIB_W]);
  assign do_commit = press[KEY_COMMIT] & ~press[KEY_MODE];
  assign do_toggle = press[KEY_MODE]   & ~press[KEY_COMMIT];
  assign do_clear  = press[KEY_COMMIT] &  press[KEY_MODE];

  // Nibble-key edges and command-key levels are not needed here.
  assign unused_key_bits_c = ^{ks[KEY_COMMIT], ks[KEY_MODE], press[KEY_NIB_MSB +: NIB_W]};

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= SINGLE;
      ptr_q  <= '0;
      fill_q <= '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digit_buf_q[k] <= '0;
      end
    end else begin
      mode_q <= mode_d;
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digit_buf_q[k] <= digit_buf_d[k];
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    digit_buf_d = digit_buf_q;
    dig_val_c   = live_nib;
    dig_dot_c   = 1'b1;
    dig_blank_c = 1'b0;

    unique case (mode_q)
      SINGLE: begin
        ptr_d = '0;
      end
      SCAN: begin
        ptr_d       = PTR_W'(ptr_q + PTR_W'(1));
        dig_val_c   = digit_buf_q[ptr_q];
        dig_dot_c   = (ptr_q == '0) && (fill_q != '0);
        dig_blank_c = ({1'b0, ptr_q} >= fill_q);
      end
    endcase

    // Both command keys together clear; otherwise exactly one acts.
    if (do_clear) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digit_buf_d[k] = '0;
      end
      fill_d = '0;
      ptr_d  = '0;
    end else if (do_toggle) begin
      mode_d = (mode_q == SINGLE) ? SCAN : SINGLE;
      ptr_d  = '0;
    end else if (do_commit) begin
      for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
        digit_buf_d[k] = digit_buf_q[k-1];
      end
      digit_buf_d[0] = live_nib;
      if (fill_q != CNT_W'(NUM_DIGITS)) begin
        fill_d = CNT_W'(fill_q + CNT_W'(1));
      end
    end
  end

  assign bus.cs_pointer = ptr_q;
  assign bus.fill_cnt   = fill_q;
  assign bus.scan_mode  = (mode_q == SCAN);
  assign bus.dig_val    = dig_val_c;
  assign bus.dig_dot    = dig_dot_c;
  assign bus.dig_blank  = dig_blank_c;

endmodule

// File: tb/tb_digit_entry_scan.sv
// Directed self-checking bench for digit_entry_scan.
`timescale 1ns/1ps
module tb_digit_entry_scan;
  import digit_entry_pkg::*;

  localparam int unsigned ND = DEF_NUM_DIGITS;

  logic        clk_1kHz = 1'b0;
  logic        rst_n;
  int unsigned n_total  = 0;
  int unsigned n_bad    = 0;

  digit_entry_scan_if #(.NUM_DIGITS(ND)) bus ();

  digit_entry_scan #(
    .NUM_DIGITS  (ND),
    .SYNC_STAGES (2)
  ) dut (
    .clk_1kHz (clk_1kHz),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_1kHz);
  endtask

  // Active-low key pattern that makes the live nibble equal v.
  function automatic logic [3:0] nib_keys(input logic [3:0] v);
    logic [3:0] k;
    for (int i = 0; i < 4; i++) k[i] = ~v[3-i];
    return k;
  endfunction

  task automatic commit(input logic [3:0] v);
    bus.key_n[3:0] = nib_keys(v);
    step(2);
    bus.key_n[KEY_COMMIT] = 1'b0;
    step(3);
    bus.key_n[KEY_COMMIT] = 1'b1;
    step(3);
  endtask

  task automatic mode_key_down();
    bus.key_n[KEY_MODE] = 1'b0;
    step(3);
  endtask

  task automatic mode_key_up();
    bus.key_n[KEY_MODE] = 1'b1;
    step(3);
  endtask

  // Walk one full scan frame starting at pointer 0; vals holds digit k in bits [4k+:4].
  task automatic scan_frame(input string tag, input int unsigned fill, input logic [31:0] vals);
    for (int p = 0; p < int'(ND); p++) begin
      chk($sformatf("%s_ptr%0d", tag, p), bus.cs_pointer, p);
      chk($sformatf("%s_blank%0d", tag, p), bus.dig_blank, (p >= int'(fill)) ? 1 : 0);
      chk($sformatf("%s_dot%0d", tag, p), bus.dig_dot, (p == 0 && fill != 0) ? 1 : 0);
      if (p < int'(fill)) chk($sformatf("%s_val%0d", tag, p), bus.dig_val, vals[4*p +: 4]);
      step(1);
    end
  endtask

  initial begin
    int found;
    rst_n     = 1'b0;
    bus.key_n = '1;
    step(2);
    chk("in_rst_mode", bus.scan_mode, 0);
    chk("in_rst_fill", bus.fill_cnt, 0);

    rst_n = 1'b1;
    step(10);
    chk("idle_mode", bus.scan_mode, 0);
    chk("idle_ptr", bus.cs_pointer, 0);
    chk("idle_val", bus.dig_val, 0);
    chk("idle_dot", bus.dig_dot, 1);
    chk("idle_blank", bus.dig_blank, 0);
    chk("idle_fill", bus.fill_cnt, 0);

    // key0 and key2 pressed -> nibble 1010; two-edge synchroniser latency
    bus.key_n[3:0] = 4'b1010;
    step(1);
    chk("nib_lat1", bus.dig_val, 0);
    step(1);
    chk("nib_A", bus.dig_val, 4'hA);
    bus.key_n[3:0] = 4'b0101;
    step(2);
    chk("nib_5", bus.dig_val, 4'h5);
    bus.key_n[3:0] = 4'b1010;
    step(2);

    // Commit held for 5 cycles must count once
    bus.key_n[KEY_COMMIT] = 1'b0;
    step(3);
    chk("commit1_fill", bus.fill_cnt, 1);
    step(2);
    bus.key_n[KEY_COMMIT] = 1'b1;
    step(3);
    chk("commit1_hold_fill", bus.fill_cnt, 1);

    mode_key_down();
    chk("scan_on_mode", bus.scan_mode, 1);
    chk("scan_on_ptr", bus.cs_pointer, 0);
    chk("buf0_val", bus.dig_val, 4'hA);
    chk("buf0_dot", bus.dig_dot, 1);
    chk("buf0_blank", bus.dig_blank, 0);
    step(1);
    chk("buf1_ptr", bus.cs_pointer, 1);
    chk("buf1_blank", bus.dig_blank, 1);
    chk("buf1_dot", bus.dig_dot, 0);
    mode_key_up();
    mode_key_down();
    chk("scan_off_mode", bus.scan_mode, 0);
    chk("scan_off_ptr", bus.cs_pointer, 0);
    chk("scan_off_val", bus.dig_val, 4'hA);
    mode_key_up();

    // Clear from SINGLE
    bus.key_n[5:4] = 2'b00;
    step(3);
    chk("clr1_fill", bus.fill_cnt, 0);
    chk("clr1_mode", bus.scan_mode, 0);
    bus.key_n[5:4] = 2'b11;
    step(3);

    // Nine commits saturate at eight; value 1 falls off
    for (int v = 1; v <= 9; v++) commit(4'(v));
    chk("sat_fill", bus.fill_cnt, 8);
    mode_key_down();
    scan_frame("sat", 8, 32'h2345_6789);
    chk("sat_wrap_ptr", bus.cs_pointer, 0);
    chk("sat_wrap_val", bus.dig_val, 4'h9);
    mode_key_up();

    // Clear while scanning: mode kept, every digit dark
    bus.key_n[5:4] = 2'b00;
    step(3);
    chk("clr2_fill", bus.fill_cnt, 0);
    chk("clr2_mode", bus.scan_mode, 1);
    scan_frame("clr2", 0, 32'h0);
    bus.key_n[5:4] = 2'b11;
    step(3);

    // Three commits made during SCAN, then re-enter SCAN at pointer 0
    commit(4'h4);
    commit(4'h5);
    commit(4'h6);
    chk("fill3", bus.fill_cnt, 3);
    mode_key_down();
    mode_key_up();
    mode_key_down();
    scan_frame("fill3", 3, 32'h0000_0456);
    chk("fill3_wrap_ptr", bus.cs_pointer, 0);
    chk("fill3_wrap_val", bus.dig_val, 4'h6);
    mode_key_up();

    // Reset mid-scan at pointer 5 with six entries
    commit(4'h7);
    commit(4'h8);
    commit(4'h9);
    chk("pre_rst_fill", bus.fill_cnt, 6);
    found = 0;
    for (int i = 0; i < 2 * int'(ND) && found == 0; i++) begin
      if (bus.cs_pointer == 5) found = 1;
      else step(1);
    end
    chk("wait_ptr5", bus.cs_pointer, 5);
    bus.key_n[3:0] = nib_keys(4'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", bus.scan_mode, 0);
    chk("arst_ptr", bus.cs_pointer, 0);
    chk("arst_fill", bus.fill_cnt, 0);
    chk("arst_val", bus.dig_val, 0);
    chk("arst_dot", bus.dig_dot, 1);
    chk("arst_blank", bus.dig_blank, 0);
    @(negedge clk_1kHz);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_nib", bus.dig_val, 4'hC);
    step(3);
    chk("post_rst_fill", bus.fill_cnt, 0);
    commit(4'hC);
    chk("post_rst_commit", bus.fill_cnt, 1);
    mode_key_down();
    chk("post_rst_scan_val", bus.dig_val, 4'hC);
    chk("post_rst_scan_ptr", bus.cs_pointer, 0);
    mode_key_up();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
